// File: rtl/arb_pkg.sv
// Shared definitions for the output-port arbiter: FSM state encoding and the
// grant-index width helper used by every file of the block.
package arb_pkg;

  // IDLE waits for a request, BUSY holds the packet lock.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Width of a port index; never narrower than one bit so a single-port build still has a port.
  function automatic int unsigned grant_width(int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the competing input ports, the downstream sink and the arbiter.
// The master side is the arbiter itself (it owns the grant); the slave side is the
// environment driving flits and downstream ready.
interface output_port_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32
);
  import arb_pkg::*;

  localparam int unsigned GW = grant_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_last;
  logic [NUM_PORTS-1:0]        in_ready;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic                        out_last;
  logic                        out_ready;
  logic [GW-1:0]               grant_id;
  logic                        busy;
  logic [15:0]                 pkt_count;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant_id, busy, pkt_count
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant_id, busy, pkt_count
  );

endinterface

// File: rtl/rr_select.sv
// Round-robin selector: owns the priority pointer, picks the first requesting port at or
// after the pointer (wrapping), and moves the pointer past a port whose packet completed.
module rr_select
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned GW = grant_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 done,
  input  logic [GW-1:0]        done_id,
  output logic [GW-1:0]        sel,
  output logic                 any_req
);

  logic [GW-1:0] ptr_q, ptr_d;

  // Scan from the highest offset down so the request closest to the pointer wins.
  always_comb begin
    logic [31:0] idx;
    idx     = '0;
    sel     = '0;
    any_req = 1'b0;
    for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
      idx = 32'(ptr_q) + 32'(k);
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[GW'(idx)]) begin
        sel     = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // Next pointer: one past the port that just finished, wrapping at NUM_PORTS.
  always_comb begin
    logic [31:0] nxt;
    nxt   = 32'(done_id) + 32'd1;
    ptr_d = ptr_q;
    if (done) ptr_d = (nxt >= NUM_PORTS) ? '0 : GW'(nxt);
  end

  // Pointer register; reset wins over a completing packet.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Packet-locking output-port arbiter: grants one input at a time in round-robin order and
// holds the grant until that input's last flit is accepted downstream.
module output_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.master bus
);

  localparam int unsigned GW = grant_width(NUM_PORTS);

  arb_state_e           state_q;
  logic [GW-1:0]        grant_q;
  logic [15:0]          count_q;
  logic [GW-1:0]        sel;
  logic                 any_req;
  logic                 xfer_last;
  logic                 out_valid;
  logic                 out_last;
  logic [DATA_W-1:0]    out_data;
  logic [NUM_PORTS-1:0] in_ready;
  logic [DATA_W-1:0]    lane [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    assign lane[i] = bus.in_data[i*DATA_W +: DATA_W];
  end

  rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.in_valid),
    .done   (xfer_last),
    .done_id(grant_q),
    .sel    (sel),
    .any_req(any_req)
  );

  // While locked, the granted input is passed straight through; everything else is quiet.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state_q == StBusy) begin
      out_valid         = bus.in_valid[grant_q];
      out_data          = lane[grant_q];
      out_last          = bus.in_last[grant_q];
      in_ready[grant_q] = bus.out_ready;
    end
  end

  assign xfer_last = (state_q == StBusy) && out_valid && bus.out_ready && out_last;

  // Lock/release FSM with the registered grant and completed-packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= sel;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (xfer_last) begin
            state_q <= StIdle;
            count_q <= count_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.in_ready  = in_ready;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == StBusy);
  assign bus.pkt_count = count_q;

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of competing input ports (legal range 1..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the flit data width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, NUM_PORTS bits: per-input flit valid.
REQ-006 The block SHALL have port in_data, input, NUM_PORTS*DATA_W bits: per-input flit data; input i occupies bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port in_last, input, NUM_PORTS bits: per-input end-of-packet marker.
REQ-008 The block SHALL have port in_ready, output, NUM_PORTS bits: per-input accept.
REQ-009 The block SHALL have ports out_valid (output, 1 bit), out_data (output, DATA_W bits) and out_last (output, 1 bit): the granted flit.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-011 The block SHALL have port grant_id, output, GW = max(1, $clog2(NUM_PORTS)) bits: the currently granted input.
REQ-012 The block SHALL have port busy, output, 1 bit: a packet is locked.
REQ-013 The block SHALL have port pkt_count, output, 16 bits: number of completed packets.

Function
REQ-014 The block SHALL implement FSM states IDLE and BUSY.
REQ-015 In IDLE, when in_valid is nonzero, the block SHALL select the first set in_valid index scanning pointer, pointer+1, ..., NUM_PORTS-1, 0, ..., pointer-1; it SHALL register that index into grant_id and enter BUSY on the next edge.
REQ-016 In IDLE with in_valid == 0, the block SHALL remain in IDLE.
REQ-017 In IDLE, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-018 In BUSY with g = grant_id, the outputs SHALL be combinational from input g: out_valid = in_valid[g], out_data = in_data[g], out_last = in_last[g], and in_ready[g] = out_ready.
REQ-019 In BUSY, every other in_ready bit SHALL be 0.
REQ-020 A transfer SHALL occur when out_valid and out_ready are both 1 in the same cycle.
REQ-021 The grant SHALL stay locked until a transfer with out_last = 1; on that edge the FSM SHALL return to IDLE.
REQ-022 On that same edge the pointer SHALL become g+1, wrapping to 0 when g == NUM_PORTS-1, and pkt_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-023 Consequence of REQ-015 and REQ-021: there is one idle cycle between consecutive packets, and a grant takes one cycle from request to the first possible transfer.
REQ-024 If in_valid[g] drops while in BUSY, the block SHALL stay in BUSY with out_valid = 0; there is no abort or timeout.
REQ-025 A single-flit packet (in_last = 1 on the first flit) SHALL release the grant after that one transfer.
REQ-026 With NUM_PORTS = 1, grant_id SHALL be constant 0 and the pointer SHALL stay at 0.
REQ-027 busy SHALL equal (state == BUSY).

Reset
REQ-028 While reset = 1, on each edge the state SHALL become IDLE and the pointer, grant_id and pkt_count SHALL become 0; reset overrides all other events.
REQ-029 Reset asserted mid-packet SHALL discard the lock with no pointer advance and no count increment; in_ready SHALL be 0 from the following cycle.
REQ-030 After reset: out_valid = 0, out_last = 0, busy = 0, in_ready = 0, and out_data is don't-care (0 recommended).

Structure
REQ-031 State encodings (IDLE = 0, BUSY = 1) and the GW width function SHALL live in shared package arb_pkg.
REQ-032 The round-robin pointer, the wrapping selection and the advance-on-completion logic SHALL be the sub-module rr_select.
REQ-033 Data muxing and the FSM SHALL live in the top module.
REQ-034 The implementation SHALL use no memories.

Verification
REQ-035 Scenario: after reset, in_valid = 4'b1111, each input sends a 2-flit packet, out_ready = 1 -> grant order 0,1,2,3, then 0 again; pkt_count = 4 after the four packets.
REQ-036 Scenario: pointer = 3 after a packet from input 2, in_valid = 4'b0011 -> grant_id = 0 (wrap-around).
REQ-037 Scenario: input 1 sends a 3-flit packet while input 2 also requests, out_ready toggles 1,0,1,0,1 -> in_ready[2] stays 0 throughout; the grant releases only on the last-flit transfer; input 2 is granted 1 cycle later.
REQ-038 Scenario: single-flit packets on input 0 only, out_ready = 1 -> one transfer every 2 cycles; pointer alternates 1 then grant 0 again.
REQ-039 Scenario: reset asserted on the 2nd flit of a 4-flit packet -> next cycle busy = 0, in_ready = 0, pkt_count unchanged at 0, and the following grant starts at input 0.
REQ-040 Scenario: pkt_count preloaded by driving 65536 packets -> pkt_count returns to 0.
